// File: rtl/ssd_scan_ctrl.sv
// Seven-segment display scanner with an APB register interface.
// DATA writes land in a shadow copy. The shadow is copied to the active copy
// at a frame boundary, or on every cycle while scanning is disabled, so a
// frame never shows a mix of old and new digits. Digit enables stay off for
// GUARD cycles at the start of each slot to prevent ghosting.
//
// APB handshake: every access is zero wait state. S_PREADY is S_PSELx &
// S_PENABLE during the access phase. A write commits on the clk edge that
// ends the access phase. Read data is valid only during the access phase of
// a read, and is 0 at all other times.
module ssd_scan_ctrl #(
  parameter int DIGITS   = 6,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2,
  parameter int INVERT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        S_PADDR,
  input  logic              S_PWRITE,
  input  logic              S_PSELx,
  input  logic              S_PENABLE,
  input  logic [15:0]       S_PWDATA,
  output logic [15:0]       S_PRDATA,
  output logic              S_PREADY,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] LAST_D = DW'(DIGITS - 1);
  localparam logic [PW-1:0] GUARD_P = PW'(GUARD);
  // XOR mask applied to active-high patterns; also the "all segments off" level.
  localparam logic [6:0] INV_MASK = (INVERT != 0) ? 7'h7F : 7'h00;

  logic [23:0]       shadow;
  logic [23:0]       active;
  logic              en;
  logic [7:0]        blank;
  logic              pending;
  logic [PW-1:0]     presc;
  logic [DW-1:0]     digit;

  logic              wr;
  logic              rd;
  logic              data_wr;
  logic              boundary;
  logic [2:0]        digit_ext;
  logic [31:0]       active_x;
  logic [3:0]        nib;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;
  logic              unused_wdata;

  // Active-high hex-to-segment table, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h67;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign wr       = S_PSELx & S_PENABLE & S_PWRITE;
  assign rd       = reset & S_PSELx & S_PENABLE & ~S_PWRITE;
  assign data_wr  = wr & (S_PADDR[1] == 1'b0);
  assign boundary = en && (presc == LAST_P) && (digit == LAST_D);
  assign S_PREADY = reset & S_PSELx & S_PENABLE;
  // Data bits [7:1] of CTRL have no register behind them.
  assign unused_wdata = ^S_PWDATA[7:1];

  // Decode the current digit and the segment and enable values for the next cycle.
  always_comb begin
    digit_ext = '0;
    digit_ext[DW-1:0] = digit;
    // Digits above 5 have no data register, so they display 0.
    active_x = {8'h00, active};
    nib = active_x[{digit_ext, 2'b00} +: 4];
    an_next = '0;
    if (en && (presc >= GUARD_P)) an_next = DIGITS'(1) << digit;
    seg_next = INV_MASK;
    if ((an_next != '0) && !blank[digit_ext]) seg_next = hex7(nib) ^ INV_MASK;
  end

  // Read mux. The bus reads 0 outside the access phase of a read.
  always_comb begin
    S_PRDATA = 16'h0000;
    if (rd) begin
      case (S_PADDR)
        2'd0: S_PRDATA = shadow[15:0];
        2'd1: S_PRDATA = {8'h00, shadow[23:16]};
        2'd2: S_PRDATA = {blank, 7'b0, en};
        default: S_PRDATA = {12'h000, pending, digit_ext};
      endcase
    end
  end

  // Register file, shadow-to-active transfer and the PENDING flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      active  <= '0;
      en      <= 1'b0;
      blank   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr && (S_PADDR == 2'd0)) shadow[15:0] <= S_PWDATA;
      if (wr && (S_PADDR == 2'd1)) shadow[23:16] <= S_PWDATA[7:0];
      if (wr && (S_PADDR == 2'd2)) begin
        en    <= S_PWDATA[0];
        blank <= S_PWDATA[15:8];
      end
      // This samples shadow before any write on the same edge, so a write on
      // the boundary cycle is held back until the next frame.
      if (!en || (boundary && pending)) active <= shadow;
      if (data_wr && en) pending <= 1'b1;
      else if (!en || boundary) pending <= 1'b0;
    end
  end

  // Slot prescaler and digit counter. Both are held at 0 while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      digit <= '0;
    end else if (!en) begin
      presc <= '0;
      digit <= '0;
    end else if (presc == LAST_P) begin
      presc <= '0;
      digit <= (digit == LAST_D) ? '0 : digit + DW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Registered digit enables and segment outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '0;
      seg <= INV_MASK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
